tone_phase_mixer: RTL

Parametrised multi-tone stimulus engine for the FIR filter test and bring-up path. It generates NUM_TONES independent phase ramps in Q3.13 radians, with runtime-programmable increments and true modulo-2π wrap. The ramps are presented as one AXI-stream vector to CORDIC sin/cos instances. The returned sine vector is averaged and decimated into the filter's input sample stream.

---
 rtl/tone_phase_mixer_pkg.sv | 32 +++
 rtl/tone_phase_mixer_if.sv | 21 ++
 rtl/tone_phase_mixer_acc.sv | 51 +++++
 rtl/tone_phase_mixer.sv | 113 +++++++++++
 4 files changed

// File: rtl/tone_phase_mixer_pkg.sv
// Shared types, fixed-point constants and helpers for the tone stimulus engine.
package fir_stim_pkg;

    // Phase word for the default 16-bit Q3.13 configuration.
    typedef logic signed [15:0] phase_t;

    // Phase-stream producer state.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } ph_state_e;

    // round(pi * 2^(width-3)), derived from pi in Q3.29 with round-half-up.
    function automatic int pi_fixed(input int unsigned width);
        longint unsigned pi_q29;
        int unsigned     shift;
        pi_q29 = 64'd1686629713;
        shift  = 32 - width;
        return int'((pi_q29 + (64'd1 << (shift - 1))) >> shift);
    endfunction

    localparam int PI_POS = 25736;
    localparam int PI_NEG = -25736;
    localparam int TWO_PI = 51472;

    // Arithmetic right shift: divide by 2^sh rounding towards minus infinity.
    function automatic logic signed [31:0] floor_shift(input logic signed [31:0] v,
                                                       input int unsigned sh);
        return v >>> sh;
    endfunction

endpackage

// File: rtl/tone_phase_mixer_if.sv
// AXI-stream phase vector bus from the tone engine to the CORDIC bank.
interface tone_phase_mixer_if #(
    parameter int NUM_TONES = 2,
    parameter int PHASE_W   = 16
);
    logic                           m_phase_tvalid;
    logic                           m_phase_tready;
    logic [NUM_TONES*PHASE_W-1:0]   m_phase_tdata;

    modport master (
        output m_phase_tvalid,
        output m_phase_tdata,
        input  m_phase_tready
    );

    modport slave (
        input  m_phase_tvalid,
        input  m_phase_tdata,
        output m_phase_tready
    );
endinterface

// File: rtl/tone_phase_mixer_acc.sv
// One tone channel: increment register, phase register and modulo-2pi wrap.
module phase_acc_wrap
    import fir_stim_pkg::*;
#(
    parameter int PHASE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               advance_i,
    input  logic               wr_en_i,
    input  logic [PHASE_W-1:0] wr_data_i,
    output logic [PHASE_W-1:0] phase_o
);
    localparam int PI_I = pi_fixed(PHASE_W);
    localparam logic signed [PHASE_W:0] PI_X     = (PHASE_W+1)'(PI_I);
    localparam logic signed [PHASE_W:0] NEG_PI_X = (PHASE_W+1)'(-PI_I);
    localparam logic signed [PHASE_W:0] TWO_PI_X = (PHASE_W+1)'(2 * PI_I);

    logic signed [PHASE_W-1:0] phase_q, phase_d;
    logic signed [PHASE_W-1:0] inc_q, inc_d;
    logic signed [PHASE_W:0]   sum_w;
    logic signed [PHASE_W:0]   wrap_w;

    // Next phase: one-bit-wider sum folded back into [-pi, pi]; both ends kept.
    always_comb begin
        sum_w = (PHASE_W+1)'(phase_q) + (PHASE_W+1)'(inc_q);
        if (sum_w > PI_X) begin
            wrap_w = sum_w - TWO_PI_X;
        end else if (sum_w < NEG_PI_X) begin
            wrap_w = sum_w + TWO_PI_X;
        end else begin
            wrap_w = sum_w;
        end
        phase_d = advance_i ? wrap_w[PHASE_W-1:0] : phase_q;
        inc_d   = wr_en_i ? $signed(wr_data_i) : inc_q;
    end

    // Phase and increment registers; an advance always sees the pre-write increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            inc_q   <= '0;
        end else begin
            phase_q <= phase_d;
            inc_q   <= inc_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/tone_phase_mixer.sv
// Multi-tone phase generator with AXI-stream output and a decimating sine mixer.
module tone_phase_mixer
    import fir_stim_pkg::*;
#(
    parameter int NUM_TONES = 2,
    parameter int PHASE_W   = 16,
    parameter int SAMPLE_W  = 16,
    parameter int DECIM     = 5
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic                                 inc_wr_en,
    input  logic [(NUM_TONES > 1 ? $clog2(NUM_TONES) : 1)-1:0] inc_wr_sel,
    input  logic [PHASE_W-1:0]                   inc_wr_data,
    tone_phase_mixer_if.master                   phase_if,
    input  logic                                 s_sin_tvalid,
    input  logic [NUM_TONES*SAMPLE_W-1:0]        s_sin_tdata,
    output logic                                 mix_tvalid,
    output logic [SAMPLE_W-1:0]                  mix_tdata
);
    localparam int LOGN  = $clog2(NUM_TONES);
    localparam int SEL_W = (NUM_TONES > 1) ? LOGN : 1;
    localparam int SUM_W = SAMPLE_W + LOGN;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

    ph_state_e state_q, state_d;
    logic      advance_w;

    logic [PHASE_W-1:0] phase_w [NUM_TONES];

    logic signed [SUM_W-1:0] sum_w;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    mix_valid_q, mix_valid_d;
    logic [SAMPLE_W-1:0]     mix_data_q, mix_data_d;

    // Producer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Leave VALID only once the pending beat is taken and enable has dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable) state_d = ST_VALID;
            ST_VALID: if (phase_if.m_phase_tready && !enable) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Stream outputs: valid from state, accept advances every channel.
    always_comb begin
        phase_if.m_phase_tvalid = (state_q == ST_VALID);
        advance_w               = (state_q == ST_VALID) && phase_if.m_phase_tready;
    end

    for (genvar k = 0; k < NUM_TONES; k++) begin : g_ch
        phase_acc_wrap #(
            .PHASE_W(PHASE_W)
        ) u_acc (
            .clk       (clk),
            .rst       (rst),
            .advance_i (advance_w),
            .wr_en_i   (inc_wr_en && (inc_wr_sel == SEL_W'(k))),
            .wr_data_i (inc_wr_data),
            .phase_o   (phase_w[k])
        );
        assign phase_if.m_phase_tdata[k*PHASE_W +: PHASE_W] = phase_w[k];
    end

    // Sign-extended sum of the sine vector and decimation bookkeeping.
    always_comb begin
        sum_w = '0;
        for (int unsigned k = 0; k < NUM_TONES; k++) begin
            sum_w = sum_w + SUM_W'($signed(s_sin_tdata[k*SAMPLE_W +: SAMPLE_W]));
        end
        cnt_d       = cnt_q;
        mix_valid_d = 1'b0;
        mix_data_d  = mix_data_q;
        if (s_sin_tvalid) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d       = '0;
                mix_valid_d = 1'b1;
                mix_data_d  = SAMPLE_W'(floor_shift(32'(sum_w), LOGN));
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Mixer registers: held sample, one-cycle strobe, decimation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            mix_valid_q <= 1'b0;
            mix_data_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            mix_valid_q <= mix_valid_d;
            mix_data_q  <= mix_data_d;
        end
    end

    assign mix_tvalid = mix_valid_q;
    assign mix_tdata  = mix_data_q;

endmodule
